// File: rtl/nco_track.sv
// Numerically controlled oscillator: phase accumulator with one-shot slew,
// whole-cycle counting and an atomic phase/cycle snapshot on dump.
module nco_track #(
    parameter int ACC_WIDTH    = 32,
    parameter int INC_WIDTH    = 32,
    parameter int OUTPUT_WIDTH = 4,
    parameter int CYCLE_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    inc_wr,
    input  logic [INC_WIDTH-1:0]    inc_in,
    input  logic                    slew_wr,
    input  logic [ACC_WIDTH-1:0]    slew_in,
    input  logic                    dump,
    output logic [OUTPUT_WIDTH-1:0] out,
    output logic                    wrap,
    output logic                    dump_valid,
    output logic [ACC_WIDTH-1:0]    dump_phase,
    output logic [CYCLE_WIDTH-1:0]  dump_cycles
);

    logic [ACC_WIDTH-1:0]   acc;
    logic [ACC_WIDTH-1:0]   acc_next;
    logic [ACC_WIDTH-1:0]   inc_reg;
    logic [ACC_WIDTH-1:0]   slew_term;
    logic [ACC_WIDTH:0]     base_sum;
    logic                   carry;
    logic [CYCLE_WIDTH-1:0] cyc_cnt;
    logic [CYCLE_WIDTH-1:0] cyc_next;

    // The carry comes only from acc + inc_reg; the slew is added afterwards
    // so it can never create or cancel a whole-cycle event.
    always_comb begin
        slew_term = slew_wr ? slew_in : '0;
        base_sum  = {1'b0, acc} + {1'b0, inc_reg};
        carry     = enable & base_sum[ACC_WIDTH];
        if (enable) begin
            acc_next = base_sum[ACC_WIDTH-1:0] + slew_term;
        end else begin
            acc_next = acc + slew_term;
        end
        cyc_next = cyc_cnt + CYCLE_WIDTH'(carry);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc         <= '0;
            inc_reg     <= '0;
            cyc_cnt     <= '0;
            wrap        <= 1'b0;
            dump_valid  <= 1'b0;
            dump_phase  <= '0;
            dump_cycles <= '0;
        end else begin
            if (inc_wr) begin
                inc_reg <= ACC_WIDTH'(inc_in);
            end
            acc        <= acc_next;
            wrap       <= carry;
            dump_valid <= dump;
            // A dump reports the post-update state, including this edge's carry.
            if (dump) begin
                dump_phase  <= acc_next;
                dump_cycles <= cyc_next;
                cyc_cnt     <= '0;
            end else begin
                cyc_cnt <= cyc_next;
            end
        end
    end

    assign out = acc[ACC_WIDTH-1 -: OUTPUT_WIDTH];

endmodule

// File: tb/tb_nco_track.sv
// Scoreboard bench for nco_track: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_nco_track;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       inc_wr;
    logic [7:0] inc_in;
    logic       slew_wr;
    logic [7:0] slew_in;
    logic       dump;
    logic [2:0] out;
    logic       wrap;
    logic       dump_valid;
    logic [7:0] dump_phase;
    logic [3:0] dump_cycles;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [2:0] out;
        logic       wrap;
        logic       dv;
        logic       chk;
        logic [7:0] dphase;
        logic [3:0] dcyc;
    } exp_t;

    exp_t expQ[$];

    nco_track #(
        .ACC_WIDTH(8),
        .INC_WIDTH(8),
        .OUTPUT_WIDTH(3),
        .CYCLE_WIDTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .inc_wr(inc_wr),
        .inc_in(inc_in),
        .slew_wr(slew_wr),
        .slew_in(slew_in),
        .dump(dump),
        .out(out),
        .wrap(wrap),
        .dump_valid(dump_valid),
        .dump_phase(dump_phase),
        .dump_cycles(dump_cycles)
    );

    always #5 clk = ~clk;

    function automatic void checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    task automatic applyStimulus(input logic en, input logic iw, input logic [7:0] inc,
                                 input logic sw, input logic [7:0] slew, input logic dmp);
        #2;
        enable  = en;
        inc_wr  = iw;
        inc_in  = inc;
        slew_wr = sw;
        slew_in = slew;
        dump    = dmp;
        @(posedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [2:0] o, input logic w, input logic dv,
                               input logic chk, input logic [7:0] dphase, input logic [3:0] dcyc);
        exp_t e;
        e.name   = name;
        e.out    = o;
        e.wrap   = w;
        e.dv     = dv;
        e.chk    = chk;
        e.dphase = dphase;
        e.dcyc   = dcyc;
        expQ.push_back(e);
    endtask

    // Asserts reset between edges, optionally with every strobe active so the
    // bench can show they are discarded, then releases it away from an edge.
    task automatic resetDut(input bit strobes, input string name);
        @(negedge clk);
        #1;
        reset = 1'b1;
        if (strobes) begin
            enable  = 1'b1;
            inc_wr  = 1'b1;
            inc_in  = 8'h77;
            slew_wr = 1'b1;
            slew_in = 8'h11;
            dump    = 1'b1;
        end
        #1;
        checkVal({name, "_out"}, 32'(out), 32'h0);
        checkVal({name, "_wrap"}, 32'(wrap), 32'h0);
        checkVal({name, "_dv"}, 32'(dump_valid), 32'h0);
        checkVal({name, "_dphase"}, 32'(dump_phase), 32'h0);
        checkVal({name, "_dcyc"}, 32'(dump_cycles), 32'h0);
        @(posedge clk);
        #2;
        reset   = 1'b0;
        enable  = 1'b0;
        inc_wr  = 1'b0;
        inc_in  = 8'h00;
        slew_wr = 1'b0;
        slew_in = 8'h00;
        dump    = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                exp_t e;
                e = expQ.pop_front();
                checkVal({e.name, "_out"}, 32'(out), 32'(e.out));
                checkVal({e.name, "_wrap"}, 32'(wrap), 32'(e.wrap));
                checkVal({e.name, "_dv"}, 32'(dump_valid), 32'(e.dv));
                if (e.chk) begin
                    checkVal({e.name, "_dphase"}, 32'(dump_phase), 32'(e.dphase));
                    checkVal({e.name, "_dcyc"}, 32'(dump_cycles), 32'(e.dcyc));
                end
            end
        end
    end

    initial begin
        logic [7:0] a;
        reset   = 1'b1;
        enable  = 1'b0;
        inc_wr  = 1'b0;
        inc_in  = 8'h00;
        slew_wr = 1'b0;
        slew_in = 8'h00;
        dump    = 1'b0;
        resetDut(1'b0, "rst0");

        // Basic run at 0x40 per cycle.
        applyStimulus(0, 1, 8'h40, 0, 8'h00, 0); checkOutput("run_load", 0, 0, 0, 1, 8'h00, 4'd0);
        applyStimulus(1, 0, 8'h00, 0, 8'h00, 0); checkOutput("run1", 2, 0, 0, 0, 8'h00, 4'd0);
        applyStimulus(1, 0, 8'h00, 0, 8'h00, 0); checkOutput("run2", 4, 0, 0, 0, 8'h00, 4'd0);
        applyStimulus(1, 0, 8'h00, 0, 8'h00, 0); checkOutput("run3", 6, 0, 0, 0, 8'h00, 4'd0);
        applyStimulus(1, 0, 8'h00, 0, 8'h00, 0); checkOutput("run4", 0, 1, 0, 0, 8'h00, 4'd0);
        applyStimulus(1, 0, 8'h00, 0, 8'h00, 0); checkOutput("run5", 2, 0, 0, 0, 8'h00, 4'd0);

        // Slew of -0x20 at acc 0x40: 0x40 + 0x40 - 0x20 = 0x60, no carry.
        applyStimulus(1, 0, 8'h00, 1, 8'hE0, 0); checkOutput("slew", 3, 0, 0, 0, 8'h00, 4'd0);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1); checkOutput("slew_dump", 3, 0, 1, 1, 8'h60, 4'd1);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 0); checkOutput("slew_hold", 3, 0, 0, 1, 8'h60, 4'd1);

        // Twenty cycles at 0x80 give ten carries.
        resetDut(1'b0, "rst1");
        applyStimulus(0, 1, 8'h80, 0, 8'h00, 0); checkOutput("cnt_load", 0, 0, 0, 0, 8'h00, 4'd0);
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(1, 0, 8'h00, 0, 8'h00, 0);
            checkOutput($sformatf("cnt%0d", i), (i % 2 == 1) ? 3'd4 : 3'd0, (i % 2 == 0), 0, 0, 8'h00, 4'd0);
        end
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1); checkOutput("cnt_dump", 0, 0, 1, 1, 8'h00, 4'd10);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 0); checkOutput("cnt_hold", 0, 0, 0, 1, 8'h00, 4'd10);
        applyStimulus(1, 0, 8'h00, 0, 8'h00, 0); checkOutput("cnt_r1", 4, 0, 0, 0, 8'h00, 4'd0);
        applyStimulus(1, 0, 8'h00, 0, 8'h00, 0); checkOutput("cnt_r2", 0, 1, 0, 0, 8'h00, 4'd0);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1); checkOutput("cnt_restart", 0, 0, 1, 1, 8'h00, 4'd1);

        // Dump on the same edge as the fourth carry.
        resetDut(1'b0, "rst2");
        applyStimulus(0, 1, 8'h40, 0, 8'h00, 0); checkOutput("dc_load", 0, 0, 0, 0, 8'h00, 4'd0);
        for (int i = 1; i <= 15; i++) begin
            a = 8'(i * 64);
            applyStimulus(1, 0, 8'h00, 0, 8'h00, 0);
            checkOutput($sformatf("dc%0d", i), a[7:5], (i % 4 == 0), 0, 0, 8'h00, 4'd0);
        end
        applyStimulus(1, 0, 8'h00, 0, 8'h00, 1); checkOutput("dc_dump", 0, 1, 1, 1, 8'h00, 4'd4);
        applyStimulus(1, 0, 8'h00, 0, 8'h00, 0); checkOutput("dc_next", 2, 0, 0, 1, 8'h00, 4'd4);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1); checkOutput("dc_zero", 2, 0, 1, 1, 8'h40, 4'd0);

        // Increment write latency: the write edge still adds 0x40.
        applyStimulus(1, 1, 8'h10, 0, 8'h00, 0); checkOutput("lat_wr", 4, 0, 0, 1, 8'h40, 4'd0);
        applyStimulus(1, 0, 8'h00, 0, 8'h00, 0); checkOutput("lat_next", 4, 0, 0, 1, 8'h40, 4'd0);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1); checkOutput("lat_dump", 4, 0, 1, 1, 8'h90, 4'd0);
        applyStimulus(1, 0, 8'h00, 0, 8'h00, 0); checkOutput("lat_a0", 5, 0, 0, 1, 8'h90, 4'd0);

        // All strobes together; dump sees the slewed phase.
        applyStimulus(1, 1, 8'h20, 1, 8'h05, 1); checkOutput("all_dump", 5, 0, 1, 1, 8'hB5, 4'd0);
        applyStimulus(1, 0, 8'h00, 0, 8'h00, 0); checkOutput("all_next", 6, 0, 0, 1, 8'hB5, 4'd0);
        // Slew overflow with enable low is not a whole cycle.
        applyStimulus(0, 0, 8'h00, 1, 8'h30, 0); checkOutput("slew_ovf", 0, 0, 0, 1, 8'hB5, 4'd0);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1); checkOutput("slew_ovf_dump", 0, 0, 1, 1, 8'h05, 4'd0);

        // Reach acc 0xA0 with five carries, then reset mid-run with strobes active.
        resetDut(1'b0, "rst3");
        applyStimulus(0, 1, 8'h20, 0, 8'h00, 0); checkOutput("mr_load", 0, 0, 0, 0, 8'h00, 4'd0);
        for (int i = 1; i <= 45; i++) begin
            a = 8'(i * 32);
            applyStimulus(1, 0, 8'h00, 0, 8'h00, 0);
            checkOutput($sformatf("mr%0d", i), a[7:5], (i % 8 == 0), 0, 0, 8'h00, 4'd0);
        end
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1); checkOutput("mr_dump", 5, 0, 1, 1, 8'hA0, 4'd5);
        resetDut(1'b1, "rst_mid");
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1, 0, 8'h00, 0, 8'h00, 0);
            checkOutput($sformatf("post%0d", i), 0, 0, 0, 1, 8'h00, 4'd0);
        end
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1); checkOutput("post_dump", 0, 0, 1, 1, 8'h00, 4'd0);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 0); checkOutput("final_idle", 0, 0, 0, 1, 8'h00, 4'd0);

        @(negedge clk);
        #1;
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_drain actual=%0d expected=0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
